// File: rtl/obuf_ld_arbiter_pkg.sv
// Shared types and helpers for the OBUF read-port arbiter.
// Beat counter width and requester id width live here so the top and any reuse agree.
package obuf_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    localparam int ID_W = 1;

    function automatic int BEAT_CNT_W(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/obuf_ld_arbiter_if.sv
// Bundle of requester, OBUF read-port and status signals around the arbiter.
// The master modport is the arbiter's view; slave is the requesters/OBUF side.
interface obuf_ld_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 256
);
    logic                  req0_v;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  req0_ready;
    logic                  req0_rd_data_v;
    logic                  req1_v;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req1_ready;
    logic                  req1_rd_data_v;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  grant_id;
    logic                  busy;

    modport master (
        input  req0_v, req0_addr, req1_v, req1_addr, mem_ready, mem_rd_data,
        output req0_ready, req0_rd_data_v, req1_ready, req1_rd_data_v,
               rd_data, mem_req, mem_addr, grant_id, busy
    );

    modport slave (
        output req0_v, req0_addr, req1_v, req1_addr, mem_ready, mem_rd_data,
        input  req0_ready, req0_rd_data_v, req1_ready, req1_rd_data_v,
               rd_data, mem_req, mem_addr, grant_id, busy
    );

endinterface

// File: rtl/obuf_ld_arbiter_rd_tag_pipe.sv
// Fixed-latency tag shift register; pushes every cycle, MSB of each entry is its valid flag.
// Used to steer returning read data back to whoever issued the beat.
module rd_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_any_valid
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | r_stage[i][WIDTH-1];
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/obuf_ld_arbiter.sv
// Two-requester OBUF read-port arbiter with BEATS-long locked groups and round-robin between groups.
// State | meaning:  IDLE - no group open;  LOCK0 - group open for req 0;  LOCK1 - group open for req 1.
module obuf_ld_arbiter
    import obuf_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 256,
    parameter int BEATS      = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               resetn,
    obuf_ld_arbiter_if.master  bus
);

    localparam int              CNT_W     = BEAT_CNT_W(BEATS);
    localparam logic [1:0]      ST_IDLE   = ARB_IDLE;
    localparam logic [1:0]      ST_LOCK0  = ARB_LOCK0;
    localparam logic [1:0]      ST_LOCK1  = ARB_LOCK1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic                  r_ptr;
    logic                  r_active;

    logic                  w_winner;
    logic                  w_grantee;
    logic                  w_grantee_v;
    logic                  w_mem_req;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [ID_W:0]         w_tag_in;
    logic [ID_W:0]         w_tag_out;
    logic                  w_tag_busy;

    // Pointer breaks ties only; a lone requester always wins, and with no requester grant_id shows the favoured one.
    always_comb begin
        w_winner = r_ptr;
        if (bus.req0_v && !bus.req1_v)
            w_winner = 1'b0;
        else if (!bus.req0_v && bus.req1_v)
            w_winner = 1'b1;
    end

    always_comb begin
        case (r_state)
            ST_LOCK0: w_grantee = 1'b0;
            ST_LOCK1: w_grantee = 1'b1;
            default:  w_grantee = w_winner;
        endcase
    end

    assign w_grantee_v = w_grantee ? bus.req1_v : bus.req0_v;
    assign w_mem_req   = w_grantee_v & r_active;
    assign w_accept    = w_mem_req & bus.mem_ready;
    assign w_mem_addr  = w_grantee ? bus.req1_addr : bus.req0_addr;
    assign w_rd_data   = bus.mem_rd_data;

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.rd_data    = w_rd_data;
    assign bus.req0_ready = w_accept & ~w_grantee;
    assign bus.req1_ready = w_accept &  w_grantee;
    assign bus.grant_id   = r_active & w_grantee;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_ptr      <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (BEATS == 1) begin
                            r_ptr <= ~w_winner;
                        end else begin
                            r_state    <= w_winner ? ST_LOCK1 : ST_LOCK0;
                            r_beat_cnt <= CNT_W'(1);
                        end
                    end
                end
                ST_LOCK0, ST_LOCK1: begin
                    if (w_accept) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state    <= ST_IDLE;
                            r_beat_cnt <= '0;
                            r_ptr      <= (r_state == ST_LOCK0);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign w_tag_in = {w_accept, w_grantee};

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY),
        .WIDTH (ID_W + 1)
    ) u_tag_pipe (
        .clk         (clk),
        .rst_n       (resetn),
        .i_din       (w_tag_in),
        .o_dout      (w_tag_out),
        .o_any_valid (w_tag_busy)
    );

    assign bus.req0_rd_data_v = w_tag_out[ID_W] & (w_tag_out[ID_W-1:0] == 1'b0);
    assign bus.req1_rd_data_v = w_tag_out[ID_W] & (w_tag_out[ID_W-1:0] == 1'b1);
    assign bus.busy           = (r_state != ST_IDLE) | w_tag_busy;

endmodule

// File: tb/tb_obuf_ld_arbiter.sv
// Directed bench for obuf_ld_arbiter: three instances cover BEATS=2/RL=1, BEATS=2/RL=3 and BEATS=1/RL=1.
// Inputs change on the falling edge; outputs are checked 1ns later, well away from the rising edge.
module tb_obuf_ld_arbiter;
    import obuf_arb_pkg::*;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_checks = 0;
    int   n_errors = 0;

    obuf_ld_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_a ();
    obuf_ld_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_b ();
    obuf_ld_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_c ();

    obuf_ld_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BEATS(2), .RD_LATENCY(1))
        u_a (.clk(clk), .resetn(rst_a), .bus(if_a.master));
    obuf_ld_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BEATS(2), .RD_LATENCY(3))
        u_b (.clk(clk), .resetn(rst_b), .bus(if_b.master));
    obuf_ld_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BEATS(1), .RD_LATENCY(1))
        u_c (.clk(clk), .resetn(rst_c), .bus(if_c.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_g;
        int exp_a [6] = '{0, 0, 1, 1, 0, 0};

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        if_a.req0_v = 1'b1; if_a.req0_addr = 8'h10; if_a.req1_v = 1'b0; if_a.req1_addr = 8'h80;
        if_a.mem_ready = 1'b1; if_a.mem_rd_data = 32'hA5A5_0001;
        if_b.req0_v = 1'b0; if_b.req0_addr = 8'h20; if_b.req1_v = 1'b0; if_b.req1_addr = 8'h90;
        if_b.mem_ready = 1'b1; if_b.mem_rd_data = 32'h0;
        if_c.req0_v = 1'b0; if_c.req0_addr = 8'h30; if_c.req1_v = 1'b0; if_c.req1_addr = 8'hA0;
        if_c.mem_ready = 1'b1; if_c.mem_rd_data = 32'h0;

        // Reset values while held in reset
        @(negedge clk);
        #1;
        chk("rst_mem_req", if_a.mem_req, 0);
        chk("rst_ready0", if_a.req0_ready, 0);
        chk("rst_busy", if_a.busy, 0);
        chk("rst_grant", if_a.grant_id, 0);
        chk("rst_rdv0", if_a.req0_rd_data_v, 0);
        chk("rd_data_pass", if_a.rd_data, 32'hA5A5_0001);

        // Single requester, two-beat group
        rst_a = 1'b1;
        #1 chk("rel_mem_req", if_a.mem_req, 0);
        step(); #1;
        chk("s1_addr0", if_a.mem_addr, 8'h10);
        chk("s1_ready0_b1", if_a.req0_ready, 1);
        step(); if_a.req0_addr = 8'h11; #1;
        chk("s1_addr1", if_a.mem_addr, 8'h11);
        chk("s1_ready0_b2", if_a.req0_ready, 1);
        chk("s1_rdv0_p1", if_a.req0_rd_data_v, 1);
        chk("s1_rdv1_p1", if_a.req1_rd_data_v, 0);
        step(); if_a.req0_v = 1'b0; #1;
        chk("s1_rdv0_p2", if_a.req0_rd_data_v, 1);
        chk("s1_rdv1_p2", if_a.req1_rd_data_v, 0);
        chk("s1_busy_tag", if_a.busy, 1);
        chk("s1_mem_req_off", if_a.mem_req, 0);
        step(); #1;
        chk("s1_idle_busy", if_a.busy, 0);
        chk("s1_rdv0_done", if_a.req0_rd_data_v, 0);

        // Both requesting from reset release: groups alternate
        rst_a = 1'b0;
        if_a.req0_v = 1'b1; if_a.req1_v = 1'b1;
        step();
        rst_a = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("s2_grant%0d", i), if_a.grant_id, exp_a[i]);
            chk($sformatf("s2_r0_%0d", i), if_a.req0_ready, exp_a[i] == 0);
            chk($sformatf("s2_r1_%0d", i), if_a.req1_ready, exp_a[i] == 1);
            step();
        end

        // Requester 0 gaps mid-group; requester 1 must wait for the lock to close
        if_a.req1_v = 1'b0; #1;
        chk("s3_r0_b1", if_a.req0_ready, 1);
        step(); if_a.req0_v = 1'b0; if_a.req1_v = 1'b1; #1;
        chk("s3_gap_r1_a", if_a.req1_ready, 0);
        chk("s3_gap_mreq_a", if_a.mem_req, 0);
        chk("s3_gap_grant_a", if_a.grant_id, 0);
        step(); #1;
        chk("s3_gap_r1_b", if_a.req1_ready, 0);
        chk("s3_gap_busy", if_a.busy, 1);
        step(); if_a.req0_v = 1'b1; #1;
        chk("s3_r0_b2", if_a.req0_ready, 1);
        chk("s3_r1_held", if_a.req1_ready, 0);
        step(); if_a.req0_v = 1'b0; #1;
        chk("s3_r1_win", if_a.req1_ready, 1);
        chk("s3_grant1", if_a.grant_id, 1);
        step(); #1;
        chk("s3_r1_b2", if_a.req1_ready, 1);
        step(); if_a.req1_v = 1'b0;

        // mem_ready stall mid-group
        if_a.req0_v = 1'b1; #1;
        chk("s4_r0_b1", if_a.req0_ready, 1);
        step(); if_a.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("s4_stall_r0_%0d", i), if_a.req0_ready, 0);
            chk($sformatf("s4_stall_r1_%0d", i), if_a.req1_ready, 0);
            chk($sformatf("s4_stall_cnt_%0d", i), u_a.r_beat_cnt, 1);
            chk($sformatf("s4_stall_st_%0d", i), u_a.r_state, ARB_LOCK0);
            chk($sformatf("s4_stall_rdv_%0d", i), if_a.req0_rd_data_v, i == 0);
            step();
        end
        if_a.mem_ready = 1'b1; #1;
        chk("s4_r0_b2", if_a.req0_ready, 1);
        chk("s4_rdv_after", if_a.req0_rd_data_v, 0);
        step(); if_a.req0_v = 1'b0; #1;
        chk("s4_rdv_b2", if_a.req0_rd_data_v, 1);
        chk("s4_state_idle", u_a.r_state, ARB_IDLE);

        // RL=3: reset with two beats in flight
        if_b.req0_v = 1'b1; if_b.req1_v = 1'b1;
        rst_b = 1'b1;
        #1 chk("s5_rel_mem_req", if_b.mem_req, 0);
        step(); #1;
        chk("s5_r0_b1", if_b.req0_ready, 1);
        step(); #1;
        chk("s5_r0_b2", if_b.req0_ready, 1);
        step(); if_b.mem_ready = 1'b0; #1;
        chk("s5_busy_inflight", if_b.busy, 1);
        chk("s5_rdv0_not_yet", if_b.req0_rd_data_v, 0);
        chk("s5_grant_pre", if_b.grant_id, 1);
        rst_b = 1'b0; #1;
        chk("s5_rst_busy", if_b.busy, 0);
        chk("s5_rst_grant", if_b.grant_id, 0);
        chk("s5_rst_mreq", if_b.mem_req, 0);
        chk("s5_rst_rdv0", if_b.req0_rd_data_v, 0);
        step(); step();
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("s5_post_rdv0_%0d", i), if_b.req0_rd_data_v, 0);
            chk($sformatf("s5_post_rdv1_%0d", i), if_b.req1_rd_data_v, 0);
            chk($sformatf("s5_post_grant_%0d", i), if_b.grant_id, 0);
            step();
        end
        if_b.mem_ready = 1'b1; #1;
        chk("s5_first_r0", if_b.req0_ready, 1);
        chk("s5_first_r1", if_b.req1_ready, 0);
        step(); if_b.req0_v = 1'b0; if_b.req1_v = 1'b0;

        // BEATS=1: grants alternate every cycle
        if_c.req0_v = 1'b1; if_c.req1_v = 1'b1;
        rst_c = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            exp_g = i % 2;
            #1;
            chk($sformatf("s6_grant%0d", i), if_c.grant_id, exp_g);
            chk($sformatf("s6_r0_%0d", i), if_c.req0_ready, exp_g == 0);
            chk($sformatf("s6_r1_%0d", i), if_c.req1_ready, exp_g == 1);
            step();
        end
        #1 chk("s6_rdv1_last", if_c.req1_rd_data_v, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
